// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the two-port RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address and data widths
//   PORT_M0 / PORT_M1       : port-index constants used by the priority
//                             pointer and the read-return tag
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: two-way request picker for ram_arbiter.
//   clk        in   clock
//   nreset     in   synchronous reset, active-high; forces both grants low
//   req0/req1  in   requests from port m0 / m1
//   gnt0/gnt1  out  one-hot (or zero) grant, combinational from req and pointer
// Build option: ARB_FIXED_PRIO_EN defined -> m0 always wins contention and the
// priority pointer register is not built; undefined -> round-robin.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic nreset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = !nreset && req0;
        gnt1 = !nreset && req1 && !req0;
    end
`else
    // Port granted most recently; the other port wins the next contention.
    logic last;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!nreset) begin
            if (req0 && req1) begin
                gnt0 = (last == PORT_M1);
                gnt1 = (last == PORT_M0);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            last <= PORT_M1;
        end else if (gnt0) begin
            last <= PORT_M0;
        end else if (gnt1) begin
            last <= PORT_M1;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous single-port RAM between masters m0, m1.
//   clk, nreset                 clock; synchronous active-high reset
//   mX_req/we/addr/wdata        command from master X, held until mX_gnt
//   mX_gnt                      command accepted this cycle (zero-wait)
//   mX_rvalid/mX_rdata          read return, one cycle after a read grant;
//                               rdata holds the last returned value otherwise
//   ram_en/we/addr/wdata        RAM command, driven from the granted master
//   ram_rdata                   RAM read data, valid one cycle after a read
// Build option: ARB_FIXED_PRIO_EN selects fixed m0 priority (see rr_pick2).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              rd_pend;   // a read was granted last cycle
    logic              rd_tag;    // which port owns that read
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;

    rr_pick2 u_pick (
        .clk    (clk),
        .nreset (nreset),
        .req0   (m0_req),
        .req1   (m1_req),
        .gnt0   (m0_gnt),
        .gnt1   (m1_gnt)
    );

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (m0_gnt) begin
            ram_en    = 1'b1;
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (m1_gnt) begin
            ram_en    = 1'b1;
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    // Returns are also masked by nreset so a read granted just before reset
    // cannot surface while reset is held.
    always_comb begin
        m0_rvalid = !nreset && rd_pend && (rd_tag == PORT_M0);
        m1_rvalid = !nreset && rd_pend && (rd_tag == PORT_M1);
        m0_rdata  = nreset ? '0 : (m0_rvalid ? ram_rdata : hold0);
        m1_rdata  = nreset ? '0 : (m1_rvalid ? ram_rdata : hold1);
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            rd_pend <= 1'b0;
            rd_tag  <= PORT_M0;
            hold0   <= '0;
            hold1   <= '0;
        end else begin
            rd_pend <= ram_en && !ram_we;
            rd_tag  <= m1_gnt ? PORT_M1 : PORT_M0;
            if (m0_rvalid) begin
                hold0 <= ram_rdata;
            end
            if (m1_rvalid) begin
                hold1 <= ram_rdata;
            end
        end
    end

endmodule
